// File: rtl/i2c_seq_pkg.sv
// Shared opcodes, i2c core register map, CR/SR bit masks and sequencer state encoding.
package i2c_seq_pkg;

  localparam logic [1:0] OP_WR    = 2'd0;
  localparam logic [1:0] OP_RD    = 2'd1;
  localparam logic [1:0] OP_POLL  = 2'd2;
  localparam logic [1:0] OP_DELAY = 2'd3;

  localparam logic [2:0] REG_PRERLO = 3'd0;
  localparam logic [2:0] REG_PRERHI = 3'd1;
  localparam logic [2:0] REG_CTR    = 3'd2;
  localparam logic [2:0] REG_TXR    = 3'd3;
  localparam logic [2:0] REG_RXR    = 3'd3;
  localparam logic [2:0] REG_CR     = 3'd4;
  localparam logic [2:0] REG_SR     = 3'd4;

  localparam logic [7:0] CR_STA   = 8'h80;
  localparam logic [7:0] CR_STO   = 8'h40;
  localparam logic [7:0] CR_RD    = 8'h20;
  localparam logic [7:0] CR_WR    = 8'h10;
  localparam logic [7:0] SR_TIP   = 8'h02;
  localparam logic [7:0] SR_RXACK = 8'h80;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BUS   = 3'd1,
    GAP   = 3'd2,
    RESP  = 3'd3,
    DELAY = 3'd4
  } seq_state_e;

endpackage

// File: rtl/i2c_seq_wb_xfer.sv
// Single-transfer Wishbone master: drives one access while 'active' and captures read data on ack.
// Optional ack watchdog is built only when I2C_SEQ_ACK_WDOG_EN is defined.
module i2c_seq_wb_xfer #(
  parameter int ACK_TO = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       active,
  input  logic       we,
  input  logic [2:0] adr,
  input  logic [7:0] wdat,
  output logic       done,
  output logic       timeout,
  output logic [7:0] rdata,
  output logic [2:0] wb_adr,
  output logic [7:0] wb_wdat,
  input  logic [7:0] wb_rdat,
  output logic       wb_we,
  output logic       wb_stb,
  output logic       wb_cyc,
  input  logic       wb_ack
);

  // Bus signals are gated so the port idles at zero outside an access.
  assign wb_cyc  = active;
  assign wb_stb  = active;
  assign wb_we   = active & we;
  assign wb_adr  = active ? adr : 3'd0;
  assign wb_wdat = (active && we) ? wdat : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 8'h00;
    end else if (active && wb_ack) begin
      rdata <= wb_rdat;
    end
  end

`ifdef I2C_SEQ_ACK_WDOG_EN
  localparam int CW = (ACK_TO < 2) ? 1 : $clog2(ACK_TO);

  logic [CW-1:0] wd_cnt;
  logic          at_limit;

  assign at_limit = (wd_cnt == CW'(ACK_TO - 1));

  always_ff @(posedge clk) begin
    if (rst || !active) begin
      wd_cnt <= '0;
    end else if (!at_limit) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // A late ack in the final watchdog cycle still wins.
  assign timeout = active & ~wb_ack & at_limit;
`else
  logic unused_ack_to;
  assign unused_ack_to = ^ACK_TO;
  assign timeout       = 1'b0;
`endif

  assign done = active & (wb_ack | timeout);

endmodule

// File: rtl/i2c_wb_cmd_seq.sv
// Command sequencer mastering the i2c_master_top Wishbone port: WR / RD / POLL / DELAY commands.
// Define I2C_SEQ_ACK_WDOG_EN to enable the Wishbone ack watchdog (error response after ACK_TO cycles).
module i2c_wb_cmd_seq
  import i2c_seq_pkg::*;
#(
  parameter int POLL_TO = 1023,
  parameter int ACK_TO  = 15
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_op_i,
  input  logic [2:0] cmd_adr_i,
  input  logic [7:0] cmd_dat_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_dat_o,
  output logic       rsp_err_o,
  output logic       busy_o,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  input  logic       wb_ack_i,
  output seq_state_e state
);

  // Handshakes: a command transfers on a clock where cmd_valid_i & cmd_ready_o; a response
  // transfers where rsp_valid_o & rsp_ready_i, and rsp_dat_o/rsp_err_o hold until then.

  localparam logic [9:0] POLL_LIM = 10'(POLL_TO);

  seq_state_e state_q, state_d;
  logic [1:0] op_q;
  logic [2:0] adr_q;
  logic [7:0] dat_q;
  logic [9:0] poll_cnt;
  logic [7:0] dly_cnt;
  logic [7:0] rsp_dat_q;
  logic       rsp_err_q;
  logic       xfer_done, xfer_timeout, poll_hit;
  logic [7:0] xfer_rdata;

  i2c_seq_wb_xfer #(.ACK_TO(ACK_TO)) u_xfer (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .active  (state_q == BUS),
    .we      (op_q == OP_WR),
    .adr     (adr_q),
    .wdat    (dat_q),
    .done    (xfer_done),
    .timeout (xfer_timeout),
    .rdata   (xfer_rdata),
    .wb_adr  (wb_adr_o),
    .wb_wdat (wb_dat_o),
    .wb_rdat (wb_dat_i),
    .wb_we   (wb_we_o),
    .wb_stb  (wb_stb_o),
    .wb_cyc  (wb_cyc_o),
    .wb_ack  (wb_ack_i)
  );

  // Nonzero masked status means the polled condition is still pending.
  assign poll_hit = ((xfer_rdata & dat_q) != 8'h00);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_d = (cmd_op_i == OP_DELAY) ? DELAY : BUS;
      end
      BUS: begin
        if (xfer_timeout)   state_d = RESP;
        else if (xfer_done) state_d = GAP;
      end
      GAP: begin
        case (op_q)
          OP_RD:   state_d = RESP;
          OP_POLL: state_d = (poll_hit && poll_cnt != POLL_LIM) ? BUS : RESP;
          default: state_d = IDLE;
        endcase
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      DELAY: begin
        if (dly_cnt == 8'h00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      op_q      <= OP_WR;
      adr_q     <= 3'd0;
      dat_q     <= 8'h00;
      poll_cnt  <= 10'd0;
      dly_cnt   <= 8'h00;
      rsp_dat_q <= 8'h00;
      rsp_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            op_q     <= cmd_op_i;
            adr_q    <= cmd_adr_i;
            dat_q    <= cmd_dat_i;
            poll_cnt <= 10'd0;
            dly_cnt  <= cmd_dat_i;
          end
        end
        BUS: begin
          if (xfer_timeout) begin
            rsp_dat_q <= 8'hFF;
            rsp_err_q <= 1'b1;
          end
        end
        GAP: begin
          rsp_dat_q <= xfer_rdata;
          rsp_err_q <= (op_q == OP_POLL) && poll_hit;
          if (op_q == OP_POLL && poll_hit && poll_cnt != POLL_LIM) poll_cnt <= poll_cnt + 1'b1;
        end
        DELAY: begin
          if (dly_cnt != 8'h00) dly_cnt <= dly_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rsp_dat_o = (state_q == RESP) ? rsp_dat_q : 8'h00;
  assign rsp_err_o = (state_q == RESP) & rsp_err_q;
  assign busy_o    = (state_q != IDLE);
  assign state     = state_q;

endmodule
